// File: rtl/exc_redirect_if.sv
// Fetch-side redirect bus between exc_redirect and the IF stage.
// master: exc_redirect (flush/stall/discard/redirect); slave: IF stage (fires, ack).
interface exc_redirect_if;
    logic        if_req_fire;
    logic        if_resp_fire;
    logic        redirect_ack;
    logic        flush;
    logic        if_stall;
    logic        if_discard;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        input  if_req_fire,
        input  if_resp_fire,
        input  redirect_ack,
        output flush,
        output if_stall,
        output if_discard,
        output redirect_valid,
        output redirect_pc
    );

    modport slave (
        output if_req_fire,
        output if_resp_fire,
        output redirect_ack,
        input  flush,
        input  if_stall,
        input  if_discard,
        input  redirect_valid,
        input  redirect_pc
    );
endinterface

// File: rtl/exc_redirect.sv
// Exception/ERET fetch redirect: flush, drain in-flight fetches, then redirect.
// Ports: clk, resetn, exc_valid, eret_valid, cp0_epc, fbus (master), busy.
module exc_redirect #(
    parameter logic [31:0] EXC_VECTOR      = 32'hBFC00380,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              exc_valid,
    input  logic              eret_valid,
    input  logic [31:0]       cp0_epc,
    exc_redirect_if.master    fbus,
    output logic              busy
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] CMAX = CW'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        REDIRECT
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] cnt_nxt;
    logic [31:0]   target;
    logic [31:0]   target_nxt;
    logic          flush_c;
    logic          discard_c;
    logic          rv_c;
    logic          event_c;

    assign event_c = exc_valid || eret_valid;
    assign cnt_nxt = outstanding
                   + CW'(fbus.if_req_fire)
                   - CW'(fbus.if_resp_fire);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            outstanding <= '0;
            target      <= '0;
        end else begin
            state       <= state_nxt;
            outstanding <= cnt_nxt;
            target      <= target_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        target_nxt = target;
        flush_c    = 1'b0;
        discard_c  = 1'b0;
        rv_c       = 1'b0;
        unique case (state)
            IDLE: begin
                flush_c   = event_c;
                discard_c = event_c && fbus.if_resp_fire;
                if (event_c) begin
                    // exception wins when both commit together
                    target_nxt = exc_valid ? EXC_VECTOR : cp0_epc;
                    state_nxt  = (cnt_nxt == '0) ? REDIRECT : DRAIN;
                end
            end
            DRAIN: begin
                discard_c = fbus.if_resp_fire;
                if (cnt_nxt == '0) begin
                    state_nxt = REDIRECT;
                end
            end
            REDIRECT: begin
                rv_c = 1'b1;
                if (fbus.redirect_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are gated by resetn so nothing leaks while reset is held,
    // even though flush/discard are combinational on the commit inputs.
    assign fbus.flush          = resetn && flush_c;
    assign fbus.if_discard     = resetn && discard_c;
    assign fbus.redirect_valid = resetn && rv_c;
    assign fbus.redirect_pc    = (resetn && rv_c) ? target : 32'h0;
    assign fbus.if_stall       = resetn && ((state != IDLE)
                                 || (outstanding == CMAX)
                                 || flush_c);
    assign busy                = resetn && (state != IDLE);

endmodule

// File: tb/tb_exc_redirect.sv
// Directed self-checking bench for exc_redirect.
// Drives the IF side of the bus and commit inputs; checks at negedge.
module tb_exc_redirect;

    localparam logic [31:0] VEC = 32'hBFC00380;

    logic        clk;
    logic        resetn;
    logic        exc_valid;
    logic        eret_valid;
    logic [31:0] cp0_epc;
    logic        busy;

    int checks;
    int failures;

    exc_redirect_if bus ();

    exc_redirect #(
        .EXC_VECTOR      (VEC),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .exc_valid  (exc_valid),
        .eret_valid (eret_valid),
        .cp0_epc    (cp0_epc),
        .fbus       (bus.master),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Illegal stimulus guards
    always @(negedge clk) begin
        if (resetn) begin
            assert (!(bus.if_req_fire && dut.outstanding == 2'd2)) else begin
                failures++;
                $error("FAIL req_at_max observed=1 expected=0");
            end
            assert (!(bus.if_resp_fire && dut.outstanding == 2'd0)) else begin
                failures++;
                $error("FAIL resp_at_zero observed=1 expected=0");
            end
            assert (!((exc_valid || eret_valid) && busy)) else begin
                failures++;
                $error("FAIL event_when_busy observed=1 expected=0");
            end
        end
    end

    initial begin
        checks           = 0;
        failures         = 0;
        resetn           = 1'b0;
        exc_valid        = 1'b0;
        eret_valid       = 1'b0;
        cp0_epc          = 32'h0;
        bus.if_req_fire  = 1'b0;
        bus.if_resp_fire = 1'b0;
        bus.redirect_ack = 1'b0;

        // Reset with toggling inputs
        nxt();
        exc_valid = 1; eret_valid = 1; cp0_epc = 32'hFFFFFFFF;
        bus.if_req_fire = 1; bus.if_resp_fire = 1; bus.redirect_ack = 1;
        smp();
        chk("rst_flush", {31'h0, bus.flush}, 0);
        chk("rst_stall", {31'h0, bus.if_stall}, 0);
        chk("rst_discard", {31'h0, bus.if_discard}, 0);
        chk("rst_rv", {31'h0, bus.redirect_valid}, 0);
        chk("rst_pc", bus.redirect_pc, 0);
        chk("rst_busy", {31'h0, busy}, 0);
        nxt();
        exc_valid = 0; eret_valid = 0; cp0_epc = 0;
        bus.if_req_fire = 0; bus.if_resp_fire = 0; bus.redirect_ack = 0;
        nxt();
        resetn = 1;
        smp();
        chk("rel_busy", {31'h0, busy}, 0);
        chk("rel_stall", {31'h0, bus.if_stall}, 0);

        // Exception, nothing in flight
        nxt();
        exc_valid = 1;
        smp();
        chk("exc_flush", {31'h0, bus.flush}, 1);
        chk("exc_stall", {31'h0, bus.if_stall}, 1);
        chk("exc_rv0", {31'h0, bus.redirect_valid}, 0);
        nxt();
        exc_valid = 0;
        smp();
        chk("exc_rv_c1", {31'h0, bus.redirect_valid}, 1);
        chk("exc_pc_c1", bus.redirect_pc, VEC);
        chk("exc_flush_off", {31'h0, bus.flush}, 0);
        nxt();
        smp();
        chk("exc_pc_c2", bus.redirect_pc, VEC);
        nxt();
        bus.redirect_ack = 1;
        smp();
        chk("exc_pc_c3", bus.redirect_pc, VEC);
        nxt();
        bus.redirect_ack = 0;
        smp();
        chk("exc_done_busy", {31'h0, busy}, 0);
        chk("exc_done_stall", {31'h0, bus.if_stall}, 0);
        chk("exc_done_rv", {31'h0, bus.redirect_valid}, 0);
        chk("exc_done_pc", bus.redirect_pc, 0);

        // ERET with two requests in flight
        bus.if_req_fire = 1;
        nxt();
        nxt();
        bus.if_req_fire = 0;
        smp();
        chk("sat_stall_idle", {31'h0, bus.if_stall}, 1);
        chk("sat_busy", {31'h0, busy}, 0);
        nxt();
        eret_valid = 1; cp0_epc = 32'h80001234;
        smp();
        chk("eret_flush", {31'h0, bus.flush}, 1);
        nxt();
        eret_valid = 0; cp0_epc = 0;
        smp();
        chk("eret_drain_flush", {31'h0, bus.flush}, 0);
        chk("eret_drain_stall", {31'h0, bus.if_stall}, 1);
        chk("eret_drain_busy", {31'h0, busy}, 1);
        chk("eret_drain_disc0", {31'h0, bus.if_discard}, 0);
        nxt();
        bus.if_resp_fire = 1;
        smp();
        chk("eret_disc1", {31'h0, bus.if_discard}, 1);
        chk("eret_rv_d1", {31'h0, bus.redirect_valid}, 0);
        nxt();
        smp();
        chk("eret_disc2", {31'h0, bus.if_discard}, 1);
        chk("eret_rv_d2", {31'h0, bus.redirect_valid}, 0);
        nxt();
        bus.if_resp_fire = 0;
        smp();
        chk("eret_rv", {31'h0, bus.redirect_valid}, 1);
        chk("eret_pc", bus.redirect_pc, 32'h80001234);
        nxt();
        bus.redirect_ack = 1;
        nxt();
        bus.redirect_ack = 0;
        smp();
        chk("eret_idle", {31'h0, busy}, 0);

        // Exception/ERET priority
        nxt();
        exc_valid = 1; eret_valid = 1; cp0_epc = 32'h80000000;
        nxt();
        exc_valid = 0; eret_valid = 0; cp0_epc = 0;
        smp();
        chk("prio_rv", {31'h0, bus.redirect_valid}, 1);
        chk("prio_pc", bus.redirect_pc, VEC);
        nxt();
        bus.redirect_ack = 1;
        nxt();
        bus.redirect_ack = 0;

        // Same-cycle fetch traffic on the event cycle
        bus.if_req_fire = 1;
        nxt();
        bus.if_req_fire = 0;
        exc_valid = 1;
        bus.if_req_fire = 1; bus.if_resp_fire = 1;
        smp();
        chk("same_disc", {31'h0, bus.if_discard}, 1);
        chk("same_flush", {31'h0, bus.flush}, 1);
        nxt();
        exc_valid = 0;
        bus.if_req_fire = 0; bus.if_resp_fire = 0;
        smp();
        chk("same_cnt", {30'h0, dut.outstanding}, 1);
        chk("same_busy", {31'h0, busy}, 1);
        chk("same_rv0", {31'h0, bus.redirect_valid}, 0);
        nxt();
        bus.if_resp_fire = 1;
        smp();
        chk("same_disc2", {31'h0, bus.if_discard}, 1);
        nxt();
        bus.if_resp_fire = 0;
        smp();
        chk("same_rv", {31'h0, bus.redirect_valid}, 1);
        chk("same_pc", bus.redirect_pc, VEC);
        nxt();
        bus.redirect_ack = 1;
        nxt();
        bus.redirect_ack = 0;

        // Reset in the middle of DRAIN
        bus.if_req_fire = 1;
        nxt();
        nxt();
        bus.if_req_fire = 0;
        eret_valid = 1; cp0_epc = 32'h80004000;
        nxt();
        eret_valid = 0; cp0_epc = 0;
        smp();
        chk("mid_busy_pre", {31'h0, busy}, 1);
        nxt();
        resetn = 0;
        #1;
        chk("mid_busy", {31'h0, busy}, 0);
        chk("mid_stall", {31'h0, bus.if_stall}, 0);
        chk("mid_rv", {31'h0, bus.redirect_valid}, 0);
        chk("mid_cnt", {30'h0, dut.outstanding}, 0);
        nxt();
        resetn = 1;
        smp();
        chk("mid_after_busy", {31'h0, busy}, 0);
        chk("mid_after_stall", {31'h0, bus.if_stall}, 0);
        nxt();
        smp();
        chk("mid_after_rv", {31'h0, bus.redirect_valid}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exc_redirect.md
Name: exc_redirect

Overview:
- Fetch-side consumer of the exception/ERET commit produced by the exception-commit stage.
- On an exception or ERET, it flushes the younger pipeline stages. It then drains the fetch requests already in flight on the instruction bus, discarding their responses.
- Finally it presents the new PC (exception vector or EPC) to the IF stage with a valid/ack handshake.
- Sits between the exception-commit stage/CP0 outputs and the IF stage / instruction-bus master.

Parameters:
- EXC_VECTOR, 32'hBFC00380, general exception entry PC.
- MAX_OUTSTANDING, 2, maximum fetch requests in flight; counter width is clog2(MAX_OUTSTANDING+1).

Ports:
- clk  in  1  clock, all state on rising edge.
- resetn  in  1  reset; asynchronous, active-low.
- exc_valid  in  1  exception committed in the commit stage this cycle.
- eret_valid  in  1  ERET committed in the commit stage this cycle.
- cp0_epc  in  32  current CP0 EPC; sampled only when eret_valid is accepted.
- if_req_fire  in  1  fetch address handshake completed this cycle.
- if_resp_fire  in  1  final fetch data beat handshake completed this cycle.
- redirect_ack  in  1  IF has loaded redirect_pc this cycle.
- flush  out  1  kill IF/ID/EX pipeline registers.
- if_stall  out  1  IF must not issue new fetch requests.
- if_discard  out  1  a response completing this cycle is stale; IF drops it.
- redirect_valid  out  1  redirect_pc is valid.
- redirect_pc  out  32  new fetch PC.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE, outstanding=0, target=0.
  - All outputs 0 while in reset and on exit.
- Outstanding counter:
  - next = outstanding + if_req_fire - if_resp_fire; req and resp in the same cycle leave it unchanged. It updates in every state.
  - if_req_fire at MAX_OUTSTANDING, or if_resp_fire at 0, is an illegal stimulus; the bench asserts it never occurs.
- Stall: if_stall = (state != IDLE) || (outstanding == MAX_OUTSTANDING) || flush.
- event = exc_valid || eret_valid.
- IDLE state:
  - flush = event, combinational in the same cycle.
  - if_discard = event && if_resp_fire.
  - On event, latch target: EXC_VECTOR if exc_valid (exception has priority when both are high), else cp0_epc.
  - On event, next state = REDIRECT if next outstanding == 0, else DRAIN.
- DRAIN state:
  - flush = 0, if_discard = if_resp_fire.
  - Go to REDIRECT in the cycle the counter's next value is 0.
- REDIRECT state:
  - redirect_valid = 1, redirect_pc = target, held stable until redirect_ack.
  - On redirect_ack, go to IDLE.
  - redirect_pc = 0 whenever redirect_valid = 0.
- exc_valid/eret_valid outside IDLE are ignored, since the commit stage is already flushed; the bench asserts they stay low.
- Latency:
  - Event with no requests in flight: redirect_valid rises the cycle after the event.
  - With requests in flight: redirect_valid rises the cycle after the last stale response.
- redirect_ack while redirect_valid=0 has no effect.
- resetn low mid-DRAIN/REDIRECT: immediate return to IDLE; outstanding cleared; no redirect is issued.

Test Plan:
- Reset check: hold resetn=0, toggle all inputs.
  - Required: all outputs 0; after release, busy=0.
- Exception with nothing in flight: exc_valid=1 for 1 cycle, outstanding=0.
  - Event cycle: flush=1, if_stall=1.
  - Next cycle: redirect_valid=1, redirect_pc=BFC00380, held for 3 cycles until redirect_ack=1.
  - Cycle after ack: busy=0, if_stall=0.
- ERET with two requests in flight: two if_req_fire, then eret_valid=1 with cp0_epc=80001234.
  - Required: flush pulse; DRAIN with if_stall=1.
  - if_discard=1 on each of 2 later resp fires.
  - redirect_valid=1 with pc=80001234 the cycle after the 2nd resp.
- Exception/ERET priority: exc_valid and eret_valid both 1, cp0_epc=80000000.
  - Required: redirect_pc=BFC00380.
- Same-cycle fetch traffic: outstanding=1, event cycle also has if_req_fire=1 and if_resp_fire=1.
  - Event cycle: if_discard=1, outstanding stays 1, state DRAIN.
  - One more resp: redirect follows.
- Saturation and mid-operation reset:
  - Two req fires with no resp: if_stall=1 in IDLE.
  - resetn=0 during DRAIN: busy/if_stall/redirect_valid=0 immediately, outstanding=0.
